mesi_snoop_responder: RTL and testbench
=======================================

// Module: mesi_snoop_responder
// PURPOSE
//  Bus-side snoop handler for one core's private cache in the 4-core MESI system.
//  Accepts snoop transactions from other cores, looks up the local tag/state array, returns a hit/shared/dirty response,
//  flushes M lines (4 words), and downgrades/invalidates the local MESI state. Receiving end of the core-side CacheController's bus requests.
// PARAMETERS
//  CORE_ID      0   this core's id (2 bits); snoops with src_core==CORE_ID are ignored
//  CACHE_LINES  64  lines in local cache (direct-mapped)
//  LINE_WORDS   4   32-bit words per line (16 B)
//  TAG_W        20  tag width; ADDR_W = TAG_W+IDX_W+OFF_W = 20+6+4 = 30
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  req_valid      in   1   snoop request valid
//  req_ready      out  1   snoop request accepted when valid&ready
//  req_op         in   2   snoop_op_t: BUS_RD=00, BUS_RDX=01, BUS_UPGR=10, RSVD=11
//  req_addr       in   30  {tag[29:10], idx[9:4], off[3:0]}
//  req_src_core   in   2   requesting core
//  lock_valid     in   1   local controller has a transaction pending on lock_idx
//  lock_idx       in   6   index locked by local controller
//  hold_valid     out  1   snoop in progress; local controller must not write hold_idx
//  hold_idx       out  6   index under snoop
//  arr_rd_en      out  1   tag/state read strobe; result valid next cycle
//  arr_rd_idx     out  6   tag/state read index
//  arr_rd_tag     in   20  stored tag
//  arr_rd_state   in   2   stored mesi_state_t
//  arr_wr_en      out  1   state write strobe (single-cycle pulse)
//  arr_wr_idx     out  6   state write index
//  arr_wr_state   out  2   new mesi_state_t
//  dat_rd_en      out  1   data word read strobe; data valid next cycle
//  dat_rd_idx     out  6   data read line index
//  dat_rd_word    out  2   data read word select
//  dat_rd_data    in   32  data word
//  rsp_valid      out  1   response beat valid
//  rsp_ready      in   1   response beat accepted
//  rsp_hit/rsp_shared/rsp_dirty  out 1 each  response flags, constant over all beats of one response
//  rsp_data       out  32  flush data (0 on non-data beat)
//  rsp_last       out  1   final beat of response
//  err            out  1   one-cycle pulse: protocol violation (UPGR on M/E, RSVD op)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, beat counter 0; reset mid-response aborts it with no array write.
//  FSM: IDLE -> LOOKUP -> DECIDE -> RESP | (FLUSH_RD <-> FLUSH_TX) -> IDLE.
//  IDLE: req_ready = !(lock_valid && lock_idx==req_addr[9:4]); ready=0 in all other states. Accept at T latches op/addr/src.
//  LOOKUP (T+1): arr_rd_en=1, arr_rd_idx=idx. hold_valid=1 from LOOKUP until return to IDLE.
//  DECIDE (T+2): hit = (arr_rd_tag==tag) && state!=I && src!=CORE_ID. Table (hit only):
//   BUS_RD : M->S flush dirty=1 shared=1 | E->S shared=1 | S->S shared=1
//   BUS_RDX: M->I flush dirty=1 | E->I, S->I shared=1
//   BUS_UPGR: S->I shared=1 | M/E->I, err pulse, no flush
//   RSVD: no hit, no write, err pulse. Miss/self-snoop: hit=shared=dirty=0, no array write.
//  Non-flush: arr_wr_en pulse in DECIDE when state changes; RESP: rsp_valid from T+3, single beat, rsp_last=1, data=0.
//  Flush (M): FLUSH_RD drives dat_rd_en, word k; FLUSH_TX presents rsp_data=dat_rd_data (registered), rsp_last=(k==3);
//   on handshake k++ -> FLUSH_RD; min 2 cycles/beat. State write (->S or ->I) pulses on cycle after last-beat handshake, then IDLE.
//  rsp_valid stays high with stable flags/data until rsp_ready (backpressure any length).
//  k wraps 3->0 only on return to IDLE; one snoop outstanding at a time.
// STRUCTURE
//  mesi_pkg: mesi_state_t, snoop_op_t, CACHE_LINES/LINE_WORDS/TAG_W/IDX_W/OFF_W constants.
//  Sub-module mesi_snoop_decode: combinational {op,state,hit} -> {next_state,shared,dirty,flush,err,wr}.
// TESTING
//  BUS_RD idx5 on E line tag match -> 1 beat hit=1 shared=1 dirty=0 at T+3, arr_wr_state=S idx5.
//  BUS_RDX on M line, words A0..A3, rsp_ready toggling -> 4 beats A0..A3 last on 4th, then arr_wr_state=I, dirty=1.
//  Tag mismatch / state I / src_core==CORE_ID -> 1 beat hit=0, no arr_wr_en.
//  lock_valid idx7 with req idx7 -> req_ready=0 until lock drops; req idx8 accepted same cycle.
//  BUS_UPGR on M -> err pulse, state->I, no data; RSVD op -> err, hit=0, no write.
//  reset asserted during beat 2 of flush -> outputs 0 immediately, no arr_wr_en, next snoop served normally.

Source files
------------

// File: rtl/mesi_pkg.sv
// mesi_pkg: MESI state/op encodings and cache geometry shared by the snoop path
package mesi_pkg;
  localparam int CACHE_LINES = 64;
  localparam int LINE_WORDS = 4;
  localparam int TAG_W = 20;
  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int OFF_W = $clog2(LINE_WORDS * 4);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  typedef enum logic [1:0] {ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11} mesi_state_t;
  typedef enum logic [1:0] {BUS_RD = 2'b00, BUS_RDX = 2'b01, BUS_UPGR = 2'b10, BUS_RSVD = 2'b11} snoop_op_t;
endpackage

// File: rtl/mesi_snoop_decode.sv
// mesi_snoop_decode: snoop op x local state -> MESI transition and response flags
module mesi_snoop_decode
  import mesi_pkg::*;
(
  input  snoop_op_t   op,
  input  mesi_state_t state,
  input  logic        hit,
  output mesi_state_t next_state,
  output logic        shared,
  output logic        dirty,
  output logic        flush,
  output logic        err,
  output logic        wr
);
  logic v;
  always_comb begin
    v = hit && op != BUS_RSVD;
    next_state = !v ? state : (op == BUS_RD ? ST_S : ST_I);
    shared = v && (op == BUS_RD || (op == BUS_RDX && state != ST_M) || (op == BUS_UPGR && state == ST_S));
    dirty = v && state == ST_M && op != BUS_UPGR;
    flush = dirty;
    // a hit already excludes I, so UPGR on anything but S means the line was M/E
    err = op == BUS_RSVD || (v && op == BUS_UPGR && state != ST_S);
    wr = next_state != state;
  end
endmodule

// File: rtl/mesi_snoop_responder.sv
// mesi_snoop_responder: bus-side snoop handler for one core's private cache;
// looks up tag/state, answers hit/shared/dirty, flushes M lines and downgrades local state
module mesi_snoop_responder
  import mesi_pkg::*;
#(
  parameter logic [1:0] CORE_ID = 2'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_src_core,
  input  logic              lock_valid,
  input  logic [IDX_W-1:0]  lock_idx,
  output logic              hold_valid,
  output logic [IDX_W-1:0]  hold_idx,
  output logic              arr_rd_en,
  output logic [IDX_W-1:0]  arr_rd_idx,
  input  logic [TAG_W-1:0]  arr_rd_tag,
  input  logic [1:0]        arr_rd_state,
  output logic              arr_wr_en,
  output logic [IDX_W-1:0]  arr_wr_idx,
  output logic [1:0]        arr_wr_state,
  output logic              dat_rd_en,
  output logic [IDX_W-1:0]  dat_rd_idx,
  output logic [WORD_W-1:0] dat_rd_word,
  input  logic [31:0]       dat_rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_shared,
  output logic              rsp_dirty,
  output logic [31:0]       rsp_data,
  output logic              rsp_last,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LOOKUP, DECIDE, RESP, FLUSH_RD, FLUSH_TX, WRBACK} fsm_t;
  fsm_t st, st_n;
  snoop_op_t op_q;
  mesi_state_t ns_q, d_next;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] src_q;
  logic [WORD_W-1:0] k;
  logic [31:0] dat_q;
  logic [IDX_W-1:0] idx;
  logic hit_q, shared_q, dirty_q, fresh, hit;
  logic d_shared, d_dirty, d_flush, d_err, d_wr;

  assign idx = addr_q[OFF_W +: IDX_W];
  assign hit = arr_rd_tag == addr_q[ADDR_W-1 -: TAG_W] && arr_rd_state != ST_I && src_q != CORE_ID;

  mesi_snoop_decode u_dec (
    .op(op_q), .state(mesi_state_t'(arr_rd_state)), .hit(hit), .next_state(d_next),
    .shared(d_shared), .dirty(d_dirty), .flush(d_flush), .err(d_err), .wr(d_wr)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      op_q <= BUS_RD;
      addr_q <= '0;
      src_q <= '0;
      k <= '0;
      hit_q <= 1'b0;
      shared_q <= 1'b0;
      dirty_q <= 1'b0;
      ns_q <= ST_I;
      fresh <= 1'b0;
      dat_q <= '0;
    end else begin
      st <= st_n;
      if (req_valid && req_ready) begin
        op_q <= snoop_op_t'(req_op);
        addr_q <= req_addr;
        src_q <= req_src_core;
      end
      if (st == DECIDE) begin
        hit_q <= hit && op_q != BUS_RSVD;
        shared_q <= d_shared;
        dirty_q <= d_dirty;
        ns_q <= d_next;
      end
      if (st == FLUSH_TX && rsp_ready && !rsp_last) k <= k + 2'd1;
      if (st == WRBACK) k <= '0;
      // the data array only holds its output for one cycle; keep it while backpressured
      fresh <= st == FLUSH_RD;
      if (fresh) dat_q <= dat_rd_data;
    end

  always_comb begin
    st_n = st;
    case (st)
      IDLE:     st_n = req_valid && req_ready ? LOOKUP : IDLE;
      LOOKUP:   st_n = DECIDE;
      DECIDE:   st_n = d_flush ? FLUSH_RD : RESP;
      RESP:     st_n = rsp_ready ? IDLE : RESP;
      FLUSH_RD: st_n = FLUSH_TX;
      FLUSH_TX: st_n = !rsp_ready ? FLUSH_TX : (rsp_last ? WRBACK : FLUSH_RD);
      WRBACK:   st_n = IDLE;
      default:  st_n = IDLE;
    endcase
    req_ready = st == IDLE && !reset && !(lock_valid && lock_idx == req_addr[OFF_W +: IDX_W]);
    hold_valid = st != IDLE;
    hold_idx = idx;
    arr_rd_en = st == LOOKUP;
    arr_rd_idx = idx;
    // flushed lines change state only after the last beat has been taken
    arr_wr_en = (st == DECIDE && d_wr && !d_flush) || st == WRBACK;
    arr_wr_idx = idx;
    arr_wr_state = !arr_wr_en ? ST_I : (st == WRBACK ? ns_q : d_next);
    dat_rd_en = st == FLUSH_RD;
    dat_rd_idx = idx;
    dat_rd_word = k;
    rsp_valid = st == RESP || st == FLUSH_TX;
    rsp_hit = rsp_valid && hit_q;
    rsp_shared = rsp_valid && shared_q;
    rsp_dirty = rsp_valid && dirty_q;
    rsp_last = st == RESP || (st == FLUSH_TX && k == 2'd3);
    rsp_data = st != FLUSH_TX ? '0 : (fresh ? dat_rd_data : dat_q);
    err = st == DECIDE && d_err;
  end
endmodule

// File: tb/tb_mesi_snoop_responder.sv
// tb_mesi_snoop_responder: directed snoops against a table-level MESI model with a per-cycle checker
module tb_mesi_snoop_responder;
  import mesi_pkg::*;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, lock_valid = 0, rsp_ready = 1;
  logic [1:0] req_op = 0, req_src_core = 0;
  logic [29:0] req_addr = 0;
  logic [5:0] lock_idx = 0, hold_idx, arr_rd_idx, arr_wr_idx, dat_rd_idx;
  logic hold_valid, arr_rd_en, arr_wr_en, dat_rd_en, rsp_valid, rsp_hit, rsp_shared, rsp_dirty, rsp_last, err;
  logic [19:0] arr_rd_tag;
  logic [1:0] arr_rd_state, arr_wr_state, dat_rd_word;
  logic [31:0] dat_rd_data, rsp_data;

  always #5 clk = ~clk;

  mesi_snoop_responder #(.CORE_ID(2'd0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src_core(req_src_core), .lock_valid(lock_valid), .lock_idx(lock_idx),
    .hold_valid(hold_valid), .hold_idx(hold_idx), .arr_rd_en(arr_rd_en), .arr_rd_idx(arr_rd_idx),
    .arr_rd_tag(arr_rd_tag), .arr_rd_state(arr_rd_state), .arr_wr_en(arr_wr_en), .arr_wr_idx(arr_wr_idx),
    .arr_wr_state(arr_wr_state), .dat_rd_en(dat_rd_en), .dat_rd_idx(dat_rd_idx), .dat_rd_word(dat_rd_word),
    .dat_rd_data(dat_rd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_shared(rsp_shared), .rsp_dirty(rsp_dirty), .rsp_data(rsp_data), .rsp_last(rsp_last), .err(err)
  );

  logic [19:0] tag_mem [64];
  logic [1:0] st_mem [64];
  logic [31:0] dat_mem [64][4];

  // array model: registered reads; data port returns garbage when not read
  always @(posedge clk) begin
    if (arr_rd_en) begin
      arr_rd_tag <= tag_mem[arr_rd_idx];
      arr_rd_state <= st_mem[arr_rd_idx];
    end
    dat_rd_data <= dat_rd_en ? dat_mem[dat_rd_idx][dat_rd_word] : $urandom;
  end

  typedef struct packed {logic hit, shared, dirty, last; logic [31:0] data;} beat_t;
  beat_t exp_q[$];
  logic [7:0] wr_q[$];
  logic [31:0] got_d[$];
  int err_exp = 0, n_cmp = 0, n_bad = 0, cyc = 0, rdy_mode = 0;
  int first_cyc, last_hs_cyc, wr_cyc, acc_cyc, n_wr = 0, n_err = 0;
  bit seen;
  logic [2:0] last_flags;
  logic [7:0] last_wr;
  logic [5:0] cur_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // what the MESI rules say one snoop must produce, given the line as the bench stored it
  task automatic model(input logic [1:0] op, input logic [29:0] a, input logic [1:0] src, output bit dty);
    logic [5:0] ix;
    logic [1:0] s, ns;
    bit h, sh;
    int nb;
    beat_t b;
    ix = a[9:4];
    s = st_mem[ix];
    ns = s;
    h = op != BUS_RSVD && tag_mem[ix] == a[29:10] && s != ST_I && src != 2'd0;
    sh = 0;
    dty = 0;
    if (op == BUS_RSVD) err_exp++;
    if (h) begin
      if (op == BUS_RD) begin ns = ST_S; sh = 1; dty = s == ST_M; end
      if (op == BUS_RDX) begin ns = ST_I; sh = s != ST_M; dty = s == ST_M; end
      if (op == BUS_UPGR) begin ns = ST_I; sh = s == ST_S; if (s != ST_S) err_exp++; end
    end
    nb = dty ? 4 : 1;
    for (int i = 0; i < nb; i++) begin
      b.hit = h; b.shared = sh; b.dirty = dty; b.last = i == nb - 1;
      b.data = dty ? dat_mem[ix][i] : 32'h0;
      exp_q.push_back(b);
    end
    if (ns != s) wr_q.push_back({ix, ns});
  endtask

  always @(negedge clk) if (!reset) begin
    if (rsp_valid) begin
      if (!seen) begin seen = 1; first_cyc = cyc; end
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        chk("rsp_flags", {rsp_hit, rsp_shared, rsp_dirty, rsp_last},
            {exp_q[0].hit, exp_q[0].shared, exp_q[0].dirty, exp_q[0].last});
        chk("rsp_data", rsp_data, exp_q[0].data);
        if (rsp_ready) begin
          last_flags = {rsp_hit, rsp_shared, rsp_dirty};
          got_d.push_back(rsp_data);
          if (rsp_last) last_hs_cyc = cyc;
          void'(exp_q.pop_front());
        end
      end
    end
    if (hold_valid) chk("hold_idx", hold_idx, cur_idx);
    if (arr_rd_en) chk("arr_rd_idx", arr_rd_idx, cur_idx);
    if (dat_rd_en) chk("dat_rd", {dat_rd_idx, dat_rd_word}, {cur_idx, 2'(4 - exp_q.size())});
    if (arr_wr_en) begin
      n_wr++;
      wr_cyc = cyc;
      last_wr = {arr_wr_idx, arr_wr_state};
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else chk("wr_idx_state", {arr_wr_idx, arr_wr_state}, wr_q.pop_front());
    end
    if (err) begin
      n_err++;
      chk("err_expected", 1, err_exp > 0);
      if (err_exp > 0) err_exp--;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    rsp_ready = rdy_mode == 0 ? 1'b1 : (rdy_mode == 1 ? !rsp_ready : 1'($urandom_range(0, 1)));
  end

  function automatic logic [29:0] mk(input logic [19:0] t, input logic [5:0] i);
    return {t, i, 4'h4};
  endfunction

  task automatic set_line(input logic [5:0] i, input logic [19:0] t, input logic [1:0] s, input logic [31:0] base);
    tag_mem[i] = t;
    st_mem[i] = s;
    for (int w = 0; w < 4; w++) dat_mem[i][w] = base + 32'(w);
  endtask

  task automatic start(input logic [1:0] op, input logic [29:0] a, input logic [1:0] src, output bit ok, output bit d);
    int n;
    @(posedge clk); #1;
    req_valid = 1; req_op = op; req_addr = a; req_src_core = src; cur_idx = a[9:4];
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    ok = req_ready;
    d = 0;
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      model(op, a, src, d);
      seen = 0; first_cyc = -1; acc_cyc = cyc; wr_cyc = -1;
    end
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic snoop(input logic [1:0] op, input logic [29:0] a, input logic [1:0] src);
    int n;
    bit ok, d, wexp;
    got_d.delete();
    start(op, a, src, ok, d);
    if (!ok) return;
    wexp = wr_q.size() > 0;
    n = 0;
    while (hold_valid && n < 300) begin @(negedge clk); n++; end
    chk("done_timeout", hold_valid, 0);
    chk("beats_left", exp_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("err_left", err_exp, 0);
    chk("latency", first_cyc - acc_cyc, d ? 4 : 3);
    if (wexp) chk("wr_timing", wr_cyc, d ? last_hs_cyc + 1 : acc_cyc + 2);
  endtask

  initial begin
    int w, e, n, drop_cyc;
    bit ok, d;
    logic [31:0] aw [4];
    aw = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    for (int i = 0; i < 64; i++) set_line(6'(i), 20'h0, ST_I, 32'h0);
    #2;
    chk("reset_outputs", {req_ready, hold_valid, arr_rd_en, arr_wr_en, dat_rd_en, rsp_valid, rsp_last, err}, 0);
    chk("reset_data", {rsp_data, arr_wr_state, dat_rd_word}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;

    set_line(5, 20'hABCDE, ST_E, 0);
    snoop(BUS_RD, mk(20'hABCDE, 5), 2'd1);
    chk("rd_e_flags", last_flags, 3'b110);
    chk("rd_e_wr", last_wr, {6'd5, ST_S});

    rdy_mode = 1;
    set_line(9, 20'h12345, ST_M, 32'hA0);
    snoop(BUS_RDX, mk(20'h12345, 9), 2'd2);
    chk("rdx_m_beats", got_d.size(), 4);
    if (got_d.size() == 4) for (int i = 0; i < 4; i++) chk("rdx_m_word", got_d[i], aw[i]);
    chk("rdx_m_flags", last_flags, 3'b101);
    chk("rdx_m_wr", last_wr, {6'd9, ST_I});

    rdy_mode = 2;
    set_line(10, 20'h0BEEF, ST_M, 32'hC0DE0000);
    snoop(BUS_RD, mk(20'h0BEEF, 10), 2'd3);
    chk("rd_m_flags", last_flags, 3'b111);
    chk("rd_m_wr", last_wr, {6'd10, ST_S});

    rdy_mode = 0;
    w = n_wr;
    set_line(11, 20'h00111, ST_S, 0);
    snoop(BUS_RD, mk(20'h00112, 11), 2'd1);
    set_line(12, 20'h00222, ST_I, 0);
    snoop(BUS_RDX, mk(20'h00222, 12), 2'd1);
    set_line(13, 20'h00333, ST_E, 0);
    snoop(BUS_RDX, mk(20'h00333, 13), 2'd0);
    chk("miss_flags", last_flags, 3'b000);
    chk("miss_no_wr", n_wr - w, 0);

    set_line(14, 20'h00444, ST_E, 0);
    snoop(BUS_RDX, mk(20'h00444, 14), 2'd1);
    chk("rdx_e_flags", last_flags, 3'b110);
    set_line(15, 20'h00555, ST_S, 0);
    snoop(BUS_RDX, mk(20'h00555, 15), 2'd2);
    chk("rdx_s_wr", last_wr, {6'd15, ST_I});

    rdy_mode = 1;
    set_line(16, 20'h00666, ST_S, 0);
    snoop(BUS_UPGR, mk(20'h00666, 16), 2'd1);
    chk("upgr_s_flags", last_flags, 3'b110);
    e = n_err;
    set_line(17, 20'h00777, ST_M, 32'hDEAD0000);
    snoop(BUS_UPGR, mk(20'h00777, 17), 2'd1);
    chk("upgr_m_err", n_err - e, 1);
    chk("upgr_m_flags", last_flags, 3'b100);
    chk("upgr_m_nodata", {got_d.size(), got_d.size() > 0 ? got_d[0] : 32'hFFFF_FFFF}, {32'd1, 32'h0});
    chk("upgr_m_wr", last_wr, {6'd17, ST_I});
    set_line(18, 20'h00888, ST_E, 0);
    snoop(BUS_UPGR, mk(20'h00888, 18), 2'd3);

    e = n_err; w = n_wr;
    set_line(19, 20'h00999, ST_E, 0);
    snoop(BUS_RSVD, mk(20'h00999, 19), 2'd1);
    chk("rsvd_err", n_err - e, 1);
    chk("rsvd_no_wr", n_wr - w, 0);
    chk("rsvd_flags", last_flags, 3'b000);

    rdy_mode = 0;
    set_line(7, 20'h07777, ST_E, 0);
    lock_valid = 1; lock_idx = 7;
    req_addr = mk(20'h07777, 8);
    @(negedge clk);
    chk("lock_other_idx", req_ready, 1);
    drop_cyc = -1;
    fork
      snoop(BUS_RD, mk(20'h07777, 7), 2'd1);
      begin
        repeat (6) begin @(negedge clk); chk("lock_block", req_ready, 0); end
        @(posedge clk); #1 lock_valid = 0; drop_cyc = cyc;
      end
    join
    chk("lock_accept_cyc", acc_cyc, drop_cyc);
    chk("lock_wr", last_wr, {6'd7, ST_S});

    rdy_mode = 1;
    w = n_wr;
    set_line(20, 20'h0F00D, ST_M, 32'hB0);
    start(BUS_RDX, mk(20'h0F00D, 20), 2'd1, ok, d);
    n = 0;
    while (!(dat_rd_en && exp_q.size() == 3) && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("beat2_valid", rsp_valid, 1);
    reset = 1;
    #1;
    chk("rst_outputs", {req_ready, hold_valid, arr_rd_en, arr_wr_en, dat_rd_en, rsp_valid, rsp_last, err}, 0);
    chk("rst_data", {rsp_data, rsp_hit, rsp_shared, rsp_dirty}, 0);
    exp_q.delete(); wr_q.delete(); err_exp = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (5) @(negedge clk);
    chk("rst_no_wr", n_wr - w, 0);
    snoop(BUS_RDX, mk(20'h0F00D, 20), 2'd1);
    chk("post_rst_beats", got_d.size(), 4);
    chk("post_rst_wr", last_wr, {6'd20, ST_I});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end
endmodule
